// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_pkg
// Brief  : Shared encodings for the MEM-stage load/store unit: access-size
//          codes, load/store FSM states and the default word-address width.
// Rev    : 1.0  initial release
// ============================================================================
package mips_pkg;

  // Default word-address width of the data memory (64K words)
  localparam int MEM_AW_DEFAULT = 16;

  // Access size encodings as presented on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Load/store FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RSP  = 2'd3
  } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_align
// Brief  : Combinational lane steering for the load/store unit.
//          Extract path : picks the addressed byte/half out of a memory word
//                         and sign- or zero-extends it.
//          Merge path   : replaces only the addressed byte/half lane of a
//                         memory word with right-justified store data.
// Ports  : rd_word_i  (32) word read from memory, source for extraction
//          mod_word_i (32) previously read word, base for the merge
//          wdata_i    (32) right-justified store data
//          lane_i     (2)  byte address bits [1:0]
//          size_i     (2)  access size code
//          unsigned_i (1)  1 = zero-extend, 0 = sign-extend
//          rdata_o    (32) extended load data
//          wword_o    (32) merged word for the write-back
// Rev    : 1.0  initial release
// ============================================================================
module lsu_align
  import mips_pkg::*;
(
  input  logic [31:0] rd_word_i,
  input  logic [31:0] mod_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] rdata_o,
  output logic [31:0] wword_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  byte_ofs;
  logic [4:0]  half_ofs;

  // Little-endian lanes: byte lane n lives at bits [8n+7:8n]
  assign byte_ofs = {lane_i, 3'b000};
  assign half_ofs = {lane_i[1], 4'b0000};

  always_comb begin
    byte_sel = rd_word_i[byte_ofs +: 8];
    half_sel = rd_word_i[half_ofs +: 16];
    rdata_o  = rd_word_i;
    case (size_i)
      SZ_BYTE: rdata_o = unsigned_i ? {24'd0, byte_sel}
                                    : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: rdata_o = unsigned_i ? {16'd0, half_sel}
                                    : {{16{half_sel[15]}}, half_sel};
      default: rdata_o = rd_word_i;
    endcase
  end

  always_comb begin
    wword_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        wword_o                 = mod_word_i;
        wword_o[byte_ofs +: 8]  = wdata_i[7:0];
      end
      SZ_HALF: begin
        wword_o                 = mod_word_i;
        wword_o[half_ofs +: 16] = wdata_i[15:0];
      end
      default: wword_o = wdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : load_store_unit
// Brief  : Byte-addressed load/store front end for a word-wide data memory.
//          One request at a time; sub-word stores are read-modify-write;
//          misaligned or illegal-size requests respond with an error and
//          never strobe the memory.
// Ports  : clk, reset (async, active-high)
//          req_valid/req_ready handshake, req_write, req_size, req_unsigned,
//          req_addr (byte address), req_wdata (right-justified)
//          resp_valid (1-cycle pulse), resp_rdata, resp_err
//          mem_addr (word index), mem_read_enable, mem_write_enable,
//          mem_write_data, mem_read_data (combinational read)
// Rev    : 1.0  initial release
// ============================================================================
module load_store_unit
  import mips_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  lsu_state_t        state_q, state_d;
  logic              write_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [MEM_AW+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              req_err;
  logic              accept;
  logic [31:0]       align_rdata;
  logic [31:0]       align_wword;

  // Address bits above the memory size wrap and are deliberately dropped
  logic              unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

  assign req_err = (req_size == SZ_ILL) ||
                   ((req_size == SZ_HALF) && req_addr[0]) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

  assign accept = req_valid && (state_q == ST_IDLE);

  lsu_align u_align (
    .rd_word_i  (mem_read_data),
    .mod_word_i (word_q),
    .wdata_i    (wdata_q),
    .lane_i     (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .rdata_o    (align_rdata),
    .wword_o    (align_wword)
  );

  // Next state and Moore outputs
  always_comb begin
    state_d          = state_q;
    req_ready        = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_write_data   = 32'd0;
    resp_valid       = 1'b0;
    mem_addr         = {{(32-MEM_AW){1'b0}}, addr_q[MEM_AW+1:2]};
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        mem_addr  = 32'd0;
        if (req_valid) begin
          if (req_err)                   state_d = ST_RSP;
          else if (!req_write)           state_d = ST_RD;
          else if (req_size == SZ_WORD)  state_d = ST_WR;
          else                           state_d = ST_RD;
        end
      end
      ST_RD: begin
        mem_read_enable = 1'b1;
        // A read here is either a load or the first half of a sub-word store
        state_d = write_q ? ST_WR : ST_RSP;
      end
      ST_WR: begin
        mem_write_enable = 1'b1;
        mem_write_data   = align_wword;
        state_d          = ST_RSP;
      end
      ST_RSP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign resp_rdata = resp_valid ? rdata_q : 32'd0;
  assign resp_err   = resp_valid & err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q <= req_write;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr[MEM_AW+1:0];
        wdata_q <= req_wdata;
        err_q   <= req_err;
        rdata_q <= 32'd0;
      end
      if (state_q == ST_RD) begin
        word_q <= mem_read_data;
        if (!write_q) rdata_q <= align_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_load_store_unit
// Brief  : Self-checking bench for load_store_unit with a word memory model
//          and a response scoreboard (data, error flag, response cycle).
// Rev    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  load_store_unit #(.MEM_AW(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .mem_addr         (mem_addr),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  always #5 clk = ~clk;

  // Word memory model with combinational read
  logic [31:0] mem [0:65535];
  assign mem_read_data = mem[mem_addr[15:0]];

  int cyc = 0;
  int wr_strobes = 0;
  int rd_strobes = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write_enable) begin
      mem[mem_addr[15:0]] <= mem_write_data;
      wr_strobes <= wr_strobes + 1;
    end
    if (mem_read_enable) rd_strobes <= rd_strobes + 1;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Response monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_resp", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_rdata", resp_rdata, mon_e.rdata);
          chk("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
          chk("resp_cycle", cyc + 1, mon_e.due);
          chk("ready_in_rsp", {31'd0, req_ready}, 32'd0);
        end
      end else begin
        chk("rdata_idle_zero", resp_rdata, 32'd0);
      end
    end
  end

  // Present one request, wait for acceptance, optionally track the response.
  // lat is the number of edges from the accept edge to the edge sampling resp.
  task automatic send(input logic wr, input logic [1:0] sz, input logic un,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee, input int lat,
                      input bit track);
    int k;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = a;
    req_wdata    = wd;
    req_valid    = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
    end else begin
      if (track) sb.push_back('{er, ee, cyc + 1 + lat});
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  int rc, wc;

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = SZ_WORD;
    req_unsigned = 1'b0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_strobes", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: word store / word load
    send(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1'b1);
    send(1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
    drain();
    chk("t1_mem4", mem[4], 32'hDEADBEEF);

    // 2: byte store as read-modify-write
    send(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344, 32'd0, 1'b0, 2, 1'b1);
    drain();
    rc = rd_strobes;
    wc = wr_strobes;
    send(1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h000000AA, 32'd0, 1'b0, 3, 1'b1);
    drain();
    chk("t2_mem4", mem[4], 32'h11AA3344);
    chk("t2_rd_strobes", rd_strobes - rc, 32'd1);
    chk("t2_wr_strobes", wr_strobes - wc, 32'd1);

    // 3: sub-word loads with extension
    send(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h80FF7F01, 32'd0, 1'b0, 2, 1'b1);
    send(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'd0, 32'hFFFFFF80, 1'b0, 2, 1'b1);
    send(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'd0, 32'h00000080, 1'b0, 2, 1'b1);
    send(1'b0, SZ_HALF, 1'b0, 32'h10, 32'd0, 32'h00007F01, 1'b0, 2, 1'b1);
    send(1'b0, SZ_HALF, 1'b0, 32'h12, 32'd0, 32'hFFFF80FF, 1'b0, 2, 1'b1);
    send(1'b0, SZ_HALF, 1'b1, 32'h12, 32'd0, 32'h000080FF, 1'b0, 2, 1'b1);
    send(1'b0, SZ_BYTE, 1'b0, 32'h10, 32'd0, 32'h00000001, 1'b0, 2, 1'b1);
    send(1'b0, SZ_BYTE, 1'b0, 32'h11, 32'd0, 32'h0000007F, 1'b0, 2, 1'b1);
    send(1'b0, SZ_BYTE, 1'b0, 32'h12, 32'd0, 32'hFFFFFFFF, 1'b0, 2, 1'b1);
    // high address bits wrap onto the same word
    send(1'b0, SZ_WORD, 1'b0, 32'h00040010, 32'd0, 32'h80FF7F01, 1'b0, 2, 1'b1);
    drain();

    // 4: misaligned and illegal-size requests
    rc = rd_strobes;
    wc = wr_strobes;
    send(1'b0, SZ_HALF, 1'b0, 32'h11, 32'd0, 32'd0, 1'b1, 1, 1'b1);
    send(1'b1, SZ_WORD, 1'b0, 32'h12, 32'h12345678, 32'd0, 1'b1, 1, 1'b1);
    send(1'b0, SZ_ILL, 1'b0, 32'h10, 32'd0, 32'd0, 1'b1, 1, 1'b1);
    send(1'b1, SZ_HALF, 1'b0, 32'h13, 32'h0000BEEF, 32'd0, 1'b1, 1, 1'b1);
    drain();
    chk("t4_rd_strobes", rd_strobes - rc, 32'd0);
    chk("t4_wr_strobes", wr_strobes - wc, 32'd0);
    chk("t4_mem4", mem[4], 32'h80FF7F01);

    // 5: back-to-back requests with req_valid held high
    send(1'b1, SZ_WORD, 1'b0, 32'h20, 32'hCAFEF00D, 32'd0, 1'b0, 2, 1'b1);
    send(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h00001234, 32'd0, 1'b0, 3, 1'b1);
    send(1'b0, SZ_HALF, 1'b1, 32'h20, 32'd0, 32'h0000F00D, 1'b0, 2, 1'b1);
    send(1'b0, SZ_HALF, 1'b0, 32'h22, 32'd0, 32'h00001234, 1'b0, 2, 1'b1);
    send(1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h00000099, 32'd0, 1'b0, 3, 1'b1);
    send(1'b0, SZ_WORD, 1'b0, 32'h20, 32'd0, 32'h1234990D, 1'b0, 2, 1'b1);
    send(1'b0, SZ_BYTE, 1'b1, 32'h21, 32'd0, 32'h00000099, 1'b0, 2, 1'b1);
    drain();
    chk("t5_mem8", mem[8], 32'h1234990D);

    // 6: reset during the write phase of a byte store
    send(1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h00000055, 32'd0, 1'b0, 3, 1'b0);
    @(negedge clk);
    chk("t6_in_wr", {31'd0, mem_write_enable}, 32'd1);
    chk("t6_wr_addr", mem_addr, 32'd4);
    wc = wr_strobes;
    reset = 1'b1;
    #1;
    chk("t6_we_dropped", {31'd0, mem_write_enable}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t6_no_write", wr_strobes - wc, 32'd0);
    chk("t6_mem4", mem[4], 32'h80FF7F01);
    send(1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0, 32'h80FF7F01, 1'b0, 2, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
